// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I control sequencer; optional INSTRET_COUNTER_EN adds 64-bit instret
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal_instr,
  output logic       bus_error
`ifdef INSTRET_COUNTER_EN
  ,
  output logic [63:0] instret
`endif
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic          in_mem;
  state_t        boundary;

  // State, wait counter and sticky fault flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state sequencing plus the memory wait timeout that overrides it
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    in_mem    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    boundary  = halt_req ? S_IDLE : S_FETCH;

    case (state_q)
      S_IDLE:   if (!halt_req) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            state_d   = S_FAULT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR:   state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_d = boundary;
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = boundary;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase

    // Counter only runs while a memory state is stalled; any exit or entry leaves it at zero
    if (in_mem && !mem_ready) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = S_FAULT;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Moore strobe decode; only ir_write/pc_write look at mem_ready/zero, halted at halt_req
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE:   halted = halt_req;
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC_R: alu_op = 2'b10;
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = 2'b11;
      end
      S_ADDR:   alu_src_b = 1'b1;
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = zero;
      end
      default: ;
    endcase
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

`ifdef INSTRET_COUNTER_EN
  logic [63:0] instret_q, instret_d;
  logic        retire;

  // An instruction retires when it leaves its last state toward the boundary
  always_comb begin
    retire    = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                ((state_q == S_MEM_WR) && mem_ready);
    instret_d = retire ? (instret_q + 64'd1) : instret_q;
  end

  // Retired-instruction counter, wraps naturally at 2^64
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  localparam int TO = 16;

  // Expected-output bit masks: {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
  // alu_src_b, alu_op[1:0], reg_write, mem_to_reg, halted, illegal_instr, bus_error}
  localparam logic [13:0] M_REQ   = 14'h2000;
  localparam logic [13:0] M_WE    = 14'h1000;
  localparam logic [13:0] M_IORD  = 14'h0800;
  localparam logic [13:0] M_IRW   = 14'h0400;
  localparam logic [13:0] M_PCW   = 14'h0200;
  localparam logic [13:0] M_PCSRC = 14'h0100;
  localparam logic [13:0] M_SRCB  = 14'h0080;
  localparam logic [13:0] M_OP_R  = 14'h0040;
  localparam logic [13:0] M_OP_I  = 14'h0060;
  localparam logic [13:0] M_OP_S  = 14'h0020;
  localparam logic [13:0] M_RW    = 14'h0010;
  localparam logic [13:0] M_M2R   = 14'h0008;
  localparam logic [13:0] M_HLT   = 14'h0004;
  localparam logic [13:0] M_ILL   = 14'h0002;
  localparam logic [13:0] M_BUS   = 14'h0001;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_BAD = 5;

  logic       clk, reset_n;
  logic [6:0] opcode;
  logic       zero, mem_ready, halt_req;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, halted, illegal_instr, bus_error;
`ifdef INSTRET_COUNTER_EN
  logic [63:0] instret;
  logic [63:0] m_instret;
  logic [63:0] q_ir[$];
  logic [63:0] mon_ir;
`endif

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .illegal_instr(illegal_instr), .bus_error(bus_error)
`ifdef INSTRET_COUNTER_EN
    , .instret(instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [13:0] q_o[$];
  logic [13:0] m_sticky;
  logic [13:0] mon_o, mon_act;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 3);
    if (r < 19) return TO - 1;
    return TO;
  endfunction

  function automatic logic [6:0] rand_bad_op();
    logic [6:0] op;
    do op = 7'($urandom);
    while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
           op == 7'b0100011 || op == 7'b1100011);
    return op;
  endfunction

  // Drive one cycle of inputs and queue the outputs that cycle must show
  task automatic step(input logic mr, input logic z, input logic h, input logic [13:0] o);
    mem_ready = mr;
    zero      = z;
    halt_req  = h;
    q_o.push_back(o | m_sticky);
`ifdef INSTRET_COUNTER_EN
    q_ir.push_back(m_instret);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
`ifdef INSTRET_COUNTER_EN
    m_instret = m_instret + 64'd1;
`endif
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    m_sticky = '0;
`ifdef INSTRET_COUNTER_EN
    m_instret = '0;
`endif
    step(rb(), rb(), 1'b0, '0);
    step(rb(), rb(), 1'b0, '0);
    reset_n = 1'b1;
    step(rb(), rb(), 1'b0, '0);
  endtask

  // Cycle list of one instruction from class, wait counts, branch flag and boundary halt
  task automatic run_instr(input int cls, input int fw, input int mw, input int zsel,
                           input logic hb, input logic [6:0] bad_op, output logic faulted);
    logic z;
    logic [13:0] mwe;
    faulted = 1'b0;
    for (int i = 0; i < fw && i < TO; i++) begin
      opcode = 7'($urandom);
      step(1'b0, rb(), rb(), M_REQ);
    end
    if (fw >= TO) begin
      m_sticky = m_sticky | M_BUS;
      faulted  = 1'b1;
      return;
    end
    opcode = 7'($urandom);
    step(1'b1, rb(), rb(), M_REQ | M_IRW | M_PCW);
    case (cls)
      C_R:     opcode = 7'b0110011;
      C_I:     opcode = 7'b0010011;
      C_LD:    opcode = 7'b0000011;
      C_ST:    opcode = 7'b0100011;
      C_BR:    opcode = 7'b1100011;
      default: opcode = bad_op;
    endcase
    step(rb(), rb(), rb(), '0);
    case (cls)
      C_R, C_I: begin
        step(rb(), rb(), rb(), (cls == C_R) ? M_OP_R : (M_OP_I | M_SRCB));
        step(rb(), rb(), hb, M_RW);
        retire();
      end
      C_LD, C_ST: begin
        mwe = (cls == C_ST) ? (M_REQ | M_IORD | M_WE) : (M_REQ | M_IORD);
        step(rb(), rb(), rb(), M_SRCB);
        for (int i = 0; i < mw && i < TO; i++) step(1'b0, rb(), rb(), mwe);
        if (mw >= TO) begin
          m_sticky = m_sticky | M_BUS;
          faulted  = 1'b1;
          return;
        end
        if (cls == C_ST) begin
          step(1'b1, rb(), hb, mwe);
        end else begin
          step(1'b1, rb(), rb(), mwe);
          step(rb(), rb(), hb, M_RW | M_M2R);
        end
        retire();
      end
      C_BR: begin
        z = (zsel == 2) ? rb() : (zsel == 1);
        step(rb(), z, hb, M_OP_S | M_PCSRC | (z ? M_PCW : 14'h0000));
        retire();
      end
      default: begin
        m_sticky = m_sticky | M_ILL;
        faulted  = 1'b1;
      end
    endcase
  endtask

  task automatic park_halted(input int k);
    for (int i = 0; i < k; i++) step(rb(), rb(), 1'b1, M_HLT);
    step(rb(), rb(), 1'b0, '0);
  endtask

  task automatic hold_fault(input int k);
    for (int i = 0; i < k; i++) step(rb(), rb(), rb(), '0);
  endtask

  // Monitor: every queued cycle is compared against the live outputs mid-cycle
  always @(negedge clk) begin
    if (q_o.size() != 0) begin
      mon_o   = q_o.pop_front();
      mon_act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_b, alu_op,
                 reg_write, mem_to_reg, halted, illegal_instr, bus_error};
      n_chk++;
      if (mon_act !== mon_o) begin
        n_fail++;
        $display("FAIL outputs t=%0t: actual %h required %h", $time, mon_act, mon_o);
      end
`ifdef INSTRET_COUNTER_EN
      mon_ir = q_ir.pop_front();
      n_chk++;
      if (instret !== mon_ir) begin
        n_fail++;
        $display("FAIL instret t=%0t: actual %0d required %0d", $time, instret, mon_ir);
      end
`endif
    end
  end

  initial begin
    logic f;
    int   cls;
    logic hb;
    reset_n   = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    halt_req  = 1'b0;
    m_sticky  = '0;
`ifdef INSTRET_COUNTER_EN
    m_instret = '0;
`endif
    @(posedge clk);
    #1;
    do_reset();

    // Directed: R-type, load with 3 waits, both branch outcomes
    run_instr(C_R, 0, 0, 2, 1'b0, '0, f);
    run_instr(C_LD, 0, 3, 2, 1'b0, '0, f);
    run_instr(C_BR, 0, 0, 1, 1'b0, '0, f);
    run_instr(C_BR, 0, 0, 0, 1'b0, '0, f);
    run_instr(C_I, 0, 0, 2, 1'b0, '0, f);
    run_instr(C_ST, 0, 2, 2, 1'b0, '0, f);

    // Directed: halt at boundary from a fresh reset, instret 0 -> 1
    do_reset();
    run_instr(C_R, 0, 0, 2, 1'b1, '0, f);
    park_halted(3);

    // Directed: fetch timeout, then fetch that completes on the last allowed cycle
    run_instr(C_R, TO, 0, 2, 1'b0, '0, f);
    hold_fault(5);
    do_reset();
    run_instr(C_R, TO - 1, 0, 2, 1'b0, '0, f);

    // Directed: illegal opcode parks in FAULT with all strobes low
    run_instr(C_BAD, 0, 0, 2, 1'b0, 7'b1111111, f);
    hold_fault(20);
    do_reset();

    // Directed: reset mid-instruction (during EXEC_R) suppresses writeback
    opcode = 7'($urandom);
    step(1'b1, rb(), 1'b0, M_REQ | M_IRW | M_PCW);
    opcode = 7'b0110011;
    step(rb(), rb(), 1'b0, '0);
    step(rb(), rb(), 1'b0, M_OP_R);
    do_reset();

    // Randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      cls = $urandom_range(0, 4);
      if ($urandom_range(0, 24) == 0) cls = C_BAD;
      hb = ($urandom_range(0, 3) == 0);
      run_instr(cls, pick_wait(), pick_wait(), 2, hb, rand_bad_op(), f);
      if (f) begin
        hold_fault($urandom_range(1, 4));
        do_reset();
      end else if (hb) begin
        park_halted($urandom_range(1, 3));
      end
    end

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the RV32I core datapath. It steps the shared ALU, register file and a single unified instruction/data memory port through fetch, decode, execute, memory and writeback phases, one instruction at a time. It replaces the purely combinational opcode decode with a Moore state machine. It also adds memory handshaking, a timeout fault and a halt interface.

Parameters:
TIMEOUT_CYCLES, 16, max cycles a memory state waits for mem_ready before faulting (>=2)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  7  instruction[6:0] from the datapath instruction register; valid from DECODE onward
zero  input  1  ALU zero flag for the branch compare
mem_ready  input  1  memory completes the current access this cycle
halt_req  input  1  request to stop at the next instruction boundary
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read
iord  output  1  memory address select: 0 = PC, 1 = ALU result
ir_write  output  1  load instruction register
pc_write  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch target
alu_src_b  output  1  0 = rs2, 1 = immediate
alu_op  output  2  00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode
reg_write  output  1  register file write enable
mem_to_reg  output  1  writeback source: 0 = ALU, 1 = memory data
halted  output  1  FSM parked in IDLE due to halt_req
illegal_instr  output  1  sticky: unsupported opcode decoded
bus_error  output  1  sticky: memory timeout

Behaviour:
- Outputs are Moore-decoded from the state register only. The one exception is pc_write and ir_write, which are gated with mem_ready/zero as noted below.
- Reset:
  - State = IDLE.
  - All outputs 0, including both sticky flags.
  - Timeout counter = 0.
  - Asserting reset_n low mid-instruction aborts the instruction immediately; no partial writeback.
- IDLE:
  - All outputs 0 except halted = halt_req.
  - halt_req=0 -> FETCH; otherwise stay.
- FETCH:
  - mem_req=1, iord=0, alu_op=00.
  - ir_write and pc_write (pc_src=0) = mem_ready.
  - On mem_ready -> DECODE.
- DECODE:
  - No strobes.
  - Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH; any other -> FAULT with illegal_instr set.
- EXEC_R: alu_src_b=0, alu_op=10 -> WB_ALU.
- EXEC_I: alu_src_b=1, alu_op=11 -> WB_ALU.
- ADDR: alu_src_b=1, alu_op=00 -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0. On mem_ready -> WB_MEM.
- MEM_WR: mem_req=1, iord=1, mem_we=1. On mem_ready -> next-instruction boundary.
- WB_ALU: reg_write=1, mem_to_reg=0 -> next-instruction boundary.
- WB_MEM: reg_write=1, mem_to_reg=1 -> next-instruction boundary.
- BRANCH:
  - alu_src_b=0, alu_op=01.
  - pc_src=1, pc_write = zero.
  - -> next-instruction boundary.
- Next-instruction boundary: halt_req=1 -> IDLE; else -> FETCH.
- Request hold: mem_req, mem_we and iord stay constant while mem_ready is low; the request is never withdrawn.
- Timeout:
  - Counter clears on entry to any memory state and increments each cycle mem_ready=0.
  - If the count reaches TIMEOUT_CYCLES-1 with mem_ready still 0 -> FAULT with bus_error set.
  - mem_ready=1 on the final cycle still completes normally.
- FAULT: all strobes 0; the FSM stays here until reset. Flags are set on the transition into FAULT.
- Latency with zero-wait memory (mem_ready tied 1): R/I = 4 cycles, load = 5, store = 4, branch = 3.
- halt_req is ignored mid-instruction; it is sampled only at the boundary and in IDLE.

Optional Feature:
INSTRET_COUNTER_EN:
- Defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 on every transition from WB_ALU, WB_MEM, MEM_WR (on mem_ready) or BRANCH.
  - Wraps at 2^64-1 -> 0.
  - Does not increment in FAULT or IDLE.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- R-type: mem_ready=1, opcode=0110011 -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write high for exactly 1 cycle at cycle 4; alu_op=10 during EXEC_R.
- Load with 3 wait cycles: opcode=0000011, mem_ready low 3 cycles in MEM_RD -> mem_req=1, iord=1 held steady; WB_MEM asserts reg_write and mem_to_reg; total 8 cycles.
- Branch: opcode=1100011, zero=1 -> pc_write=1 and pc_src=1 in BRANCH; with zero=0 -> pc_write=0; 3 cycles each.
- Illegal opcode: opcode=1111111 -> FAULT the cycle after DECODE; illegal_instr=1; all strobes stay 0 for 20 cycles; reset_n low clears the flag and returns to IDLE.
- Timeout: TIMEOUT_CYCLES=16, mem_ready held 0 in FETCH -> bus_error=1 after 16 FETCH cycles; a second run with mem_ready=1 on the 16th cycle completes the fetch without a fault.
- Halt, plus INSTRET_COUNTER_EN: halt_req=1 during EXEC_R -> WB_ALU completes, then IDLE with halted=1; instret increments 0 -> 1; releasing halt_req -> FETCH the next cycle.
